// File: rtl/flag_bank_ctrl.sv
// Bank of sticky event flags with per-channel saturating counters, overflow
// tracking, edge/level event qualification and an enable-masked priority encoder.
module flag_bank_ctrl #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 8,
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [N_CH-1:0]         i_evt,
   input  logic [N_CH-1:0]         i_edge_mode,
   input  logic [N_CH-1:0]         i_clr_reg,
   input  logic                    i_clr_all,
   input  logic [N_CH-1:0]         i_irq_en,
   output logic [N_CH-1:0]         o_flag,
   output logic [N_CH-1:0]         o_ovf,
   output logic [N_CH*CNT_W-1:0]   o_cnt,
   output logic                    o_irq,
   output logic                    o_first_vld,
   output logic [IDX_W-1:0]        o_first_idx
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [N_CH-1:0]       evt_prev_q, evt_prev_d;
   logic [N_CH-1:0]       clr_prev_q, clr_prev_d;
   logic [N_CH-1:0]       flag_q, flag_d;
   logic [N_CH-1:0]       ovf_q, ovf_d;
   logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;

   logic [N_CH-1:0]       evt_hit_s;
   logic [N_CH-1:0]       clr_hit_s;
   logic [N_CH-1:0]       pend_s;
   logic [IDX_W-1:0]      first_idx_s;

   // Qualify events and clears per channel from the sampled previous values.
   always_comb begin
      evt_hit_s = {N_CH{1'b0}};
      clr_hit_s = {N_CH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         if (i_edge_mode[k]) begin
            evt_hit_s[k] = i_evt[k] & ~evt_prev_q[k];
         end else begin
            evt_hit_s[k] = i_evt[k];
         end
         clr_hit_s[k] = (i_clr_reg[k] & ~clr_prev_q[k]) | i_clr_all;
      end
   end

   // Per-channel next state; an event always wins over a same-cycle clear so no event is lost.
   always_comb begin
      evt_prev_d = i_evt;
      clr_prev_d = i_clr_reg;
      flag_d     = flag_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      for (int k = 0; k < N_CH; k++) begin
         case ({evt_hit_s[k], clr_hit_s[k]})
            2'b11: begin
               flag_d[k]                 = 1'b1;
               ovf_d[k]                  = 1'b0;
               cnt_d[k*CNT_W +: CNT_W]   = CNT_ONE;
            end
            2'b10: begin
               flag_d[k] = 1'b1;
               ovf_d[k]  = ovf_q[k] | flag_q[k];
               if (cnt_q[k*CNT_W +: CNT_W] == CNT_MAX) begin
                  cnt_d[k*CNT_W +: CNT_W] = CNT_MAX;
               end else begin
                  cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_ONE;
               end
            end
            2'b01: begin
               flag_d[k]               = 1'b0;
               ovf_d[k]                = 1'b0;
               cnt_d[k*CNT_W +: CNT_W] = {CNT_W{1'b0}};
            end
            default: begin
               flag_d[k]               = flag_q[k];
               ovf_d[k]                = ovf_q[k];
               cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W];
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset taking priority over all activity.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         evt_prev_q <= {N_CH{1'b0}};
         clr_prev_q <= {N_CH{1'b0}};
         flag_q     <= {N_CH{1'b0}};
         ovf_q      <= {N_CH{1'b0}};
         cnt_q      <= {(N_CH*CNT_W){1'b0}};
      end else begin
         evt_prev_q <= evt_prev_d;
         clr_prev_q <= clr_prev_d;
         flag_q     <= flag_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   // Lowest-index enabled pending flag; scanning downward lets the lowest index overwrite last.
   always_comb begin
      pend_s      = flag_q & i_irq_en;
      first_idx_s = {IDX_W{1'b0}};
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (pend_s[k]) begin
            first_idx_s = IDX_W'(k);
         end else begin
            first_idx_s = first_idx_s;
         end
      end
   end

   assign o_flag      = flag_q;
   assign o_ovf       = ovf_q;
   assign o_cnt       = cnt_q;
   assign o_irq       = |pend_s;
   assign o_first_vld = |pend_s;
   assign o_first_idx = first_idx_s;

endmodule

// File: tb/tb_flag_bank_ctrl.sv
// Directed self-checking bench for flag_bank_ctrl; a second instance with
// CNT_W = 2 shares the stimulus to exercise counter saturation.
module tb_flag_bank_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  i_evt, i_edge_mode, i_clr_reg, i_irq_en;
   logic        i_clr_all;
   logic [7:0]  o_flag, o_ovf, o_flag2, o_ovf2;
   logic [63:0] o_cnt;
   logic [15:0] o_cnt2;
   logic        o_irq, o_first_vld, o_irq2, o_first_vld2;
   logic [2:0]  o_first_idx, o_first_idx2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   flag_bank_ctrl #(.N_CH(8), .CNT_W(8)) dut (
      .clk(clk), .rstn(rstn), .i_evt(i_evt), .i_edge_mode(i_edge_mode),
      .i_clr_reg(i_clr_reg), .i_clr_all(i_clr_all), .i_irq_en(i_irq_en),
      .o_flag(o_flag), .o_ovf(o_ovf), .o_cnt(o_cnt), .o_irq(o_irq),
      .o_first_vld(o_first_vld), .o_first_idx(o_first_idx)
   );

   flag_bank_ctrl #(.N_CH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rstn(rstn), .i_evt(i_evt), .i_edge_mode(i_edge_mode),
      .i_clr_reg(i_clr_reg), .i_clr_all(i_clr_all), .i_irq_en(i_irq_en),
      .o_flag(o_flag2), .o_ovf(o_ovf2), .o_cnt(o_cnt2), .o_irq(o_irq2),
      .o_first_vld(o_first_vld2), .o_first_idx(o_first_idx2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] cnt8(input int ch);
      return o_cnt[ch*8 +: 8];
   endfunction

   initial begin
      rstn = 1'b0; i_evt = 8'h00; i_edge_mode = 8'h00; i_clr_reg = 8'h00;
      i_clr_all = 1'b0; i_irq_en = 8'hFF;
      step(2);
      chk("rst_flag", o_flag, 8'h00);
      chk("rst_ovf", o_ovf, 8'h00);
      chk("rst_cnt", o_cnt, 64'h0);
      chk("rst_irq", o_irq, 1'b0);
      chk("rst_vld", o_first_vld, 1'b0);
      chk("rst_idx", o_first_idx, 3'd0);
      rstn = 1'b1;
      step(1);

      // Channel 2 pulse mode, three high cycles
      i_irq_en = 8'h04; i_evt = 8'h04;
      step(1);
      chk("p2_flag_lat", o_flag[2], 1'b1);
      chk("p2_cnt1", cnt8(2), 8'd1);
      chk("p2_ovf_first", o_ovf[2], 1'b0);
      step(2);
      i_evt = 8'h00;
      chk("p2_cnt3", cnt8(2), 8'd3);
      chk("p2_ovf", o_ovf[2], 1'b1);
      chk("p2_irq", o_irq, 1'b1);
      chk("p2_vld", o_first_vld, 1'b1);
      chk("p2_idx", o_first_idx, 3'd2);
      i_clr_all = 1'b1;
      step(1);
      i_clr_all = 1'b0;
      chk("clr_all", o_flag, 8'h00);

      // Channel 0 edge mode: held level counts once, clear is edge-triggered
      i_edge_mode = 8'h01; i_evt = 8'h01;
      step(5);
      chk("e0_cnt", cnt8(0), 8'd1);
      chk("e0_ovf", o_ovf[0], 1'b0);
      chk("e0_flag", o_flag[0], 1'b1);
      i_evt = 8'h00; i_clr_reg = 8'h01;
      step(1);
      chk("e0_clr_flag", o_flag[0], 1'b0);
      chk("e0_clr_cnt", cnt8(0), 8'd0);
      chk("e0_clr_ovf", o_ovf[0], 1'b0);
      i_evt = 8'h01;
      step(2);
      chk("e0_hold_flag", o_flag[0], 1'b1);
      chk("e0_hold_cnt", cnt8(0), 8'd1);
      i_evt = 8'h00; i_clr_reg = 8'h00; i_edge_mode = 8'h00; i_clr_all = 1'b1;
      step(1);
      i_clr_all = 1'b0;

      // Channel 1: event and clear edge in the same cycle
      i_evt = 8'h02;
      step(5);
      chk("c1_cnt5", cnt8(1), 8'd5);
      chk("c1_ovf_pre", o_ovf[1], 1'b1);
      i_clr_reg = 8'h02;
      step(1);
      chk("c1_flag", o_flag[1], 1'b1);
      chk("c1_cnt", cnt8(1), 8'd1);
      chk("c1_ovf", o_ovf[1], 1'b0);
      i_evt = 8'h00; i_clr_reg = 8'h00; i_clr_all = 1'b1;
      step(1);
      i_clr_all = 1'b0;

      // Channel 3 saturation on the 2-bit counter instance
      i_evt = 8'h08;
      step(6);
      i_evt = 8'h00;
      chk("s3_sat", o_cnt2[6 +: 2], 2'd3);
      chk("s3_wide", cnt8(3), 8'd6);
      step(1);
      chk("s3_stay", o_cnt2[6 +: 2], 2'd3);
      i_clr_all = 1'b1;
      step(1);
      i_clr_all = 1'b0;

      // Priority encode under enable mask
      i_evt = 8'h52;
      step(1);
      i_evt = 8'h00;
      i_irq_en = 8'hFD;
      #1;
      chk("pe_idx", o_first_idx, 3'd4);
      chk("pe_vld", o_first_vld, 1'b1);
      i_irq_en = 8'h00;
      #1;
      chk("pe_irq0", o_irq, 1'b0);
      chk("pe_vld0", o_first_vld, 1'b0);
      chk("pe_idx0", o_first_idx, 3'd0);
      chk("pe_keep", o_flag, 8'h52);

      // Mid-run reset overrides a same-cycle event, then clear-all vs event on ch5
      i_irq_en = 8'hFF; i_evt = 8'hFF;
      step(1);
      chk("all_set", o_flag, 8'hFF);
      rstn = 1'b0; i_evt = 8'h01;
      step(1);
      rstn = 1'b1; i_evt = 8'h00;
      chk("mr_flag", o_flag, 8'h00);
      chk("mr_ovf", o_ovf, 8'h00);
      chk("mr_cnt", o_cnt, 64'h0);
      chk("mr_irq", o_irq, 1'b0);
      i_clr_all = 1'b1; i_evt = 8'h20;
      step(1);
      i_clr_all = 1'b0; i_evt = 8'h00;
      chk("ca_flag", o_flag, 8'h20);
      chk("ca_cnt5", cnt8(5), 8'd1);
      chk("ca_idx", o_first_idx, 3'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
